// File: rtl/gpio_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_ctrl_v2
//  Description : Register-mapped GPIO block with input synchroniser, per-pin
//                tick-based debounce, and level/edge interrupt generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl_v2 #(
    parameter int GPIO_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CNT_WIDTH = 16,
    parameter int DB_SAMPLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  gpio_irq,
    input  logic                  reg_wr,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    output logic [DATA_WIDTH-1:0] reg_rdata
);

    // Sample counter must be able to hold DB_SAMPLES-1; acceptance happens on
    // the tick that would make it reach DB_SAMPLES.
    localparam int              SCW          = $clog2(DB_SAMPLES + 1);
    localparam logic [SCW-1:0]  SAMPLES_LAST = SCW'(DB_SAMPLES - 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_IN    = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_OUT   = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DIR        = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_EN     = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_TYPE   = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_POL    = ADDR_WIDTH'(8'h14);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_STATUS = ADDR_WIDTH'(8'h18);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SET        = ADDR_WIDTH'(8'h1C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLR        = ADDR_WIDTH'(8'h20);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOGGLE     = ADDR_WIDTH'(8'h24);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ_BOTH   = ADDR_WIDTH'(8'h28);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DB_EN      = ADDR_WIDTH'(8'h2C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DB_PERIOD  = ADDR_WIDTH'(8'h30);

    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
    logic [GPIO_WIDTH-1:0] irq_type_q, irq_type_d;
    logic [GPIO_WIDTH-1:0] irq_pol_q, irq_pol_d;
    logic [GPIO_WIDTH-1:0] irq_both_q, irq_both_d;
    logic [GPIO_WIDTH-1:0] db_en_q, db_en_d;
    logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [GPIO_WIDTH-1:0] filt_q, filt_d;
    logic [GPIO_WIDTH-1:0] filt_dly_q, filt_dly_d;
    logic [DB_CNT_WIDTH-1:0] db_period_q, db_period_d;
    logic [DB_CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q, sync_d;
    logic [GPIO_WIDTH-1:0][SCW-1:0] samp_cnt_q, samp_cnt_d;

    logic [GPIO_WIDTH-1:0] wdata_g;
    logic [GPIO_WIDTH-1:0] status_w1c;
    logic [GPIO_WIDTH-1:0] sync_out;
    logic [GPIO_WIDTH-1:0] edge_det;
    logic                  period_wr;
    logic                  tick;

    assign wdata_g  = reg_wdata[GPIO_WIDTH-1:0];
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    // Enable masks only the output; status keeps recording regardless.
    assign gpio_irq = |(irq_status_q & irq_en_q);

    // Register-file writes, including SET/CLR/TOGGLE modifiers and W1C strobe.
    always_comb begin
        data_out_d  = data_out_q;
        dir_d       = dir_q;
        irq_en_d    = irq_en_q;
        irq_type_d  = irq_type_q;
        irq_pol_d   = irq_pol_q;
        irq_both_d  = irq_both_q;
        db_en_d     = db_en_q;
        db_period_d = db_period_q;
        status_w1c  = '0;
        period_wr   = 1'b0;
        if (reg_wr) begin
            case (reg_addr)
                ADDR_DATA_OUT:   data_out_d = wdata_g;
                ADDR_DIR:        dir_d      = wdata_g;
                ADDR_IRQ_EN:     irq_en_d   = wdata_g;
                ADDR_IRQ_TYPE:   irq_type_d = wdata_g;
                ADDR_IRQ_POL:    irq_pol_d  = wdata_g;
                ADDR_IRQ_STATUS: status_w1c = wdata_g;
                ADDR_SET:        data_out_d = data_out_q | wdata_g;
                ADDR_CLR:        data_out_d = data_out_q & ~wdata_g;
                ADDR_TOGGLE:     data_out_d = data_out_q ^ wdata_g;
                ADDR_IRQ_BOTH:   irq_both_d = wdata_g;
                ADDR_DB_EN:      db_en_d    = wdata_g;
                ADDR_DB_PERIOD: begin
                    db_period_d = reg_wdata[DB_CNT_WIDTH-1:0];
                    period_wr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Synchroniser shift and shared debounce tick generator.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
        tick   = (tick_cnt_q == db_period_q);
        if (period_wr || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + DB_CNT_WIDTH'(1);
        end
    end

    // Per-pin debounce: accept a new level after DB_SAMPLES differing ticks.
    always_comb begin
        filt_d     = filt_q;
        samp_cnt_d = samp_cnt_q;
        filt_dly_d = filt_q;
        for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (!db_en_q[i]) begin
                filt_d[i]     = sync_out[i];
                samp_cnt_d[i] = '0;
            end else if (tick) begin
                if (sync_out[i] == filt_q[i]) begin
                    samp_cnt_d[i] = '0;
                end else if (samp_cnt_q[i] == SAMPLES_LAST) begin
                    filt_d[i]     = sync_out[i];
                    samp_cnt_d[i] = '0;
                end else begin
                    samp_cnt_d[i] = samp_cnt_q[i] + SCW'(1);
                end
            end
        end
    end

    // Interrupt status: sticky edge capture (set wins over W1C) or live level.
    always_comb begin
        edge_det = irq_type_q &
                   ((irq_both_q & (filt_q ^ filt_dly_q)) |
                    (~irq_both_q & ~irq_pol_q & filt_q & ~filt_dly_q) |
                    (~irq_both_q &  irq_pol_q & ~filt_q & filt_dly_q));
        irq_status_d = (irq_type_q & ((irq_status_q & ~status_w1c) | edge_det)) |
                       (~irq_type_q & (filt_q ^ irq_pol_q));
    end

    // Combinational register read; unmapped and write-only addresses read 0.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            ADDR_DATA_IN:    reg_rdata = DATA_WIDTH'(filt_q);
            ADDR_DATA_OUT:   reg_rdata = DATA_WIDTH'(data_out_q);
            ADDR_DIR:        reg_rdata = DATA_WIDTH'(dir_q);
            ADDR_IRQ_EN:     reg_rdata = DATA_WIDTH'(irq_en_q);
            ADDR_IRQ_TYPE:   reg_rdata = DATA_WIDTH'(irq_type_q);
            ADDR_IRQ_POL:    reg_rdata = DATA_WIDTH'(irq_pol_q);
            ADDR_IRQ_STATUS: reg_rdata = DATA_WIDTH'(irq_status_q);
            ADDR_IRQ_BOTH:   reg_rdata = DATA_WIDTH'(irq_both_q);
            ADDR_DB_EN:      reg_rdata = DATA_WIDTH'(db_en_q);
            ADDR_DB_PERIOD:  reg_rdata = DATA_WIDTH'(db_period_q);
            default:         reg_rdata = '0;
        endcase
    end

    // State registers; everything clears asynchronously so no edge is seen at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            irq_en_q     <= '0;
            irq_type_q   <= '0;
            irq_pol_q    <= '0;
            irq_both_q   <= '0;
            db_en_q      <= '0;
            irq_status_q <= '0;
            filt_q       <= '0;
            filt_dly_q   <= '0;
            db_period_q  <= '0;
            tick_cnt_q   <= '0;
            sync_q       <= '0;
            samp_cnt_q   <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            irq_en_q     <= irq_en_d;
            irq_type_q   <= irq_type_d;
            irq_pol_q    <= irq_pol_d;
            irq_both_q   <= irq_both_d;
            db_en_q      <= db_en_d;
            irq_status_q <= irq_status_d;
            filt_q       <= filt_d;
            filt_dly_q   <= filt_dly_d;
            db_period_q  <= db_period_d;
            tick_cnt_q   <= tick_cnt_d;
            sync_q       <= sync_d;
            samp_cnt_q   <= samp_cnt_d;
        end
    end

endmodule
`default_nettype wire
